// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared constants, word layout and state encoding for the obstacle field
package flappy_pkg;

  localparam int SCREEN_W_PX = 640;
  localparam int SCREEN_H_PX = 480;
  localparam int BOX         = 16;

  // Pipe word layout
  localparam int HGT_LSB = 0;
  localparam int HGT_W   = 10;
  localparam int X_LSB   = 10;
  localparam int X_W     = 10;
  localparam int GAP_LSB = 20;
  localparam int GAP_W   = 8;

  // Coin word layout
  localparam int COIN_X_LSB = 0;
  localparam int COIN_Y_LSB = 10;
  localparam int COIN_V_BIT = 31;

  // Field state entered on reset or when play stops
  localparam int X_START = 400;
  localparam int H_START = 200;
  localparam int G_START = 120;

  // Coin sits just right of the respawned pipe's left edge, centred in its gap
  localparam int COIN_X_OFS = 17;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MOVE,
    CHECK,
    FROZEN
  } state_t;

  function automatic logic [31:0] pack_pipe(input logic [9:0] h, input logic [9:0] x,
                                            input logic [7:0] g);
    logic [31:0] w;
    w = '0;
    w[HGT_LSB +: HGT_W] = h;
    w[X_LSB +: X_W]     = x;
    w[GAP_LSB +: GAP_W] = g;
    return w;
  endfunction

  function automatic logic [31:0] pack_coin(input logic [9:0] x, input logic [9:0] y,
                                            input logic v);
    logic [31:0] w;
    w = '0;
    w[COIN_X_LSB +: 10] = x;
    w[COIN_Y_LSB +: 10] = y;
    w[COIN_V_BIT]       = v;
    return w;
  endfunction

  // Bits [lsb+7:lsb] of v rotated left by n
  function automatic logic [7:0] rot_byte(input logic [15:0] v, input int n, input int lsb);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = v[4'((lsb + i + 16 - (n % 16)) % 16)];
    end
    return b;
  endfunction

  function automatic logic [3:0] rot_nib(input logic [15:0] v, input int n, input int lsb);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) begin
      b[i] = v[4'((lsb + i + 16 - (n % 16)) % 16)];
    end
    return b;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR, taps 16/14/13/11
module lfsr16
  import flappy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else begin
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end
  end

endmodule

// File: rtl/pipe_field_ctrl.sv
// rtl/pipe_field_ctrl.sv - scrolling pipe/coin field advanced once per video frame
// Each frame runs WAIT -> MOVE (positions) -> CHECK (events); a collision freezes the field.
module pipe_field_ctrl
  import flappy_pkg::*;
#(
  parameter int SPEED    = 2,
  parameter int SPACING  = 220,
  parameter int H_MIN    = 60,
  parameter int GAP_MIN  = 100,
  parameter int MARIO_X  = 70,
  parameter int PIPE_W   = 50,
  parameter int SCREEN_H = SCREEN_H_PX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_tick,
  input  logic        run,
  input  logic [9:0]  mario_y,
  output logic [31:0] pipe_1,
  output logic [31:0] pipe_2,
  output logic [31:0] pipe_3,
  output logic [31:0] coin,
  output logic        pass_pulse,
  output logic        coin_pulse,
  output logic        hit
);

  localparam logic [9:0]  SPD     = 10'(SPEED);
  localparam logic [9:0]  RESPAWN = 10'(3 * SPACING);
  localparam logic [9:0]  HMIN    = 10'(H_MIN);
  localparam logic [7:0]  GMIN    = 8'(GAP_MIN);
  localparam logic [9:0]  CHAR_X  = 10'(MARIO_X);
  localparam logic [9:0]  BOX_W   = 10'(BOX);
  localparam logic [9:0]  PASS_X  = 10'(MARIO_X - PIPE_W + SPEED);
  localparam logic [9:0]  ZONE_LO = 10'(MARIO_X - PIPE_W);
  localparam logic [9:0]  ZONE_HI = 10'(MARIO_X + BOX);
  localparam logic [10:0] BOTTOM  = 11'(SCREEN_H);
  localparam logic [9:0]  COIN_DX = 10'(COIN_X_OFS);
  localparam logic [9:0]  COIN_DY = 10'(BOX / 2);

  state_t      fsm;
  logic [15:0] lfsr;

  logic [9:0] x_q     [3];
  logic [9:0] old_x_q [3];
  logic [9:0] h_q     [3];
  logic [7:0] g_q     [3];
  logic [9:0] coin_x;
  logic [9:0] coin_y;
  logic       coin_v;

  logic [9:0] x_mv [3];
  logic [9:0] h_rs [3];
  logic [7:0] g_rs [3];
  logic [2:0] respawn;
  logic [2:0] passed;
  logic [2:0] collide_p;

  logic [10:0] my_lo;
  logic [10:0] my_hi;
  logic        collision;
  logic [9:0]  coin_dx;
  logic [9:0]  coin_dy;
  logic        collect;
  logic        spawn;
  logic [9:0]  spawn_x;
  logic [9:0]  spawn_y;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign my_lo = {1'b0, mario_y};
  assign my_hi = my_lo + 11'(BOX);

  for (genvar k = 0; k < 3; k++) begin : g_pipe
    // Pipes draw from different LFSR rotations so simultaneous respawns differ
    assign respawn[k]   = x_q[k] < SPD;
    assign x_mv[k]      = respawn[k] ? (x_q[k] - SPD + RESPAWN) : (x_q[k] - SPD);
    assign h_rs[k]      = HMIN + {2'b00, rot_byte(lfsr, 5 * (k + 1), 0)};
    assign g_rs[k]      = GMIN + {2'b00, rot_nib(lfsr, 5 * (k + 1), 10), 2'b00};
    assign passed[k]    = (old_x_q[k] >= PASS_X) && (x_q[k] < PASS_X);
    assign collide_p[k] = (x_q[k] > ZONE_LO) && (x_q[k] < ZONE_HI) &&
                          ((my_lo < {1'b0, h_q[k]}) ||
                           (my_hi > ({1'b0, h_q[k]} + {3'b000, g_q[k]})));
  end

  assign collision = (|collide_p) || (my_hi >= BOTTOM);

  assign coin_dx = (coin_x > CHAR_X) ? (coin_x - CHAR_X) : (CHAR_X - coin_x);
  assign coin_dy = (coin_y > mario_y) ? (coin_y - mario_y) : (mario_y - coin_y);
  assign collect = coin_v && (coin_dx < BOX_W) && (coin_dy < BOX_W);

  // Lowest-index respawning pipe hosts a new coin; descending loop lets it win
  always_comb begin
    spawn   = 1'b0;
    spawn_x = '0;
    spawn_y = '0;
    for (int k = 2; k >= 0; k--) begin
      if (respawn[k]) begin
        spawn   = 1'b1;
        spawn_x = x_mv[k] + COIN_DX;
        spawn_y = h_rs[k] + {3'b000, g_rs[k][7:1]} - COIN_DY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      fsm <= IDLE;
      for (int k = 0; k < 3; k++) begin
        x_q[k]     <= 10'(X_START + k * SPACING);
        old_x_q[k] <= 10'(X_START + k * SPACING);
        h_q[k]     <= 10'(H_START);
        g_q[k]     <= 8'(G_START);
      end
      coin_x     <= '0;
      coin_y     <= '0;
      coin_v     <= 1'b0;
      pass_pulse <= 1'b0;
      coin_pulse <= 1'b0;
      hit        <= 1'b0;
    end else begin
      pass_pulse <= 1'b0;
      coin_pulse <= 1'b0;
      case (fsm)
        IDLE: fsm <= WAIT;
        WAIT: begin
          if (f_tick) fsm <= MOVE;
        end
        MOVE: begin
          for (int k = 0; k < 3; k++) begin
            old_x_q[k] <= x_q[k];
            x_q[k]     <= x_mv[k];
            if (respawn[k]) begin
              h_q[k] <= h_rs[k];
              g_q[k] <= g_rs[k];
            end
          end
          if (coin_v) begin
            coin_x <= coin_x - SPD;
            if (coin_x < SPD) coin_v <= 1'b0;
          end else if (spawn && lfsr[15]) begin
            coin_x <= spawn_x;
            coin_y <= spawn_y;
            coin_v <= 1'b1;
          end
          fsm <= CHECK;
        end
        CHECK: begin
          pass_pulse <= |passed;
          coin_pulse <= collect;
          if (collect) coin_v <= 1'b0;
          hit <= collision;
          fsm <= collision ? FROZEN : WAIT;
        end
        FROZEN:  fsm <= FROZEN;
        default: fsm <= IDLE;
      endcase
    end
  end

  assign pipe_1 = pack_pipe(h_q[0], x_q[0], g_q[0]);
  assign pipe_2 = pack_pipe(h_q[1], x_q[1], g_q[1]);
  assign pipe_3 = pack_pipe(h_q[2], x_q[2], g_q[2]);
  assign coin   = pack_coin(coin_x, coin_y, coin_v);

endmodule

// File: tb/tb_pipe_field_ctrl.sv
// tb/tb_pipe_field_ctrl.sv - randomized frame stimulus against a frame-level field model
module tb_pipe_field_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_tick = 1'b0;
  logic        run = 1'b0;
  logic [9:0]  mario_y = 10'd200;
  logic [31:0] pipe_1, pipe_2, pipe_3, coin;
  logic        pass_pulse, coin_pulse, hit;

  pipe_field_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .f_tick     (f_tick),
    .run        (run),
    .mario_y    (mario_y),
    .pipe_1     (pipe_1),
    .pipe_2     (pipe_2),
    .pipe_3     (pipe_3),
    .coin       (coin),
    .pass_pulse (pass_pulse),
    .coin_pulse (coin_pulse),
    .hit        (hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          evt;
    logic [31:0] p1, p2, p3, cn;
    bit          pp, cp, ht;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] m_lfsr;

  logic [9:0] mx [3];
  logic [9:0] mh [3];
  logic [7:0] mg [3];
  logic [9:0] mcx, mcy;
  bit         mcv;
  bit         frozen;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  // Reference copy of the free-running random source, seen at negedge
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= rst ? 16'hACE1 : lfsr_next(m_lfsr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mx[k] = 10'(400 + 220 * k);
      mh[k] = 10'd200;
      mg[k] = 8'd120;
    end
    mcx = '0; mcy = '0; mcv = 1'b0; frozen = 1'b0;
  endtask

  task automatic push(input int due, input bit evt, input bit pp, input bit cp, input bit ht);
    exp_t e;
    e.due = due; e.evt = evt; e.pp = pp; e.cp = cp; e.ht = ht;
    e.p1 = {4'h0, mg[0], mx[0], mh[0]};
    e.p2 = {4'h0, mg[1], mx[1], mh[1]};
    e.p3 = {4'h0, mg[2], mx[2], mh[2]};
    e.cn = {mcv, 11'd0, mcy, mcx};
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    bit   evt_now;
    forever begin
      @(negedge clk);
      evt_now = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("schedule", cyc, e.due);
        chk("pipe_1", pipe_1, e.p1);
        chk("pipe_2", pipe_2, e.p2);
        chk("pipe_3", pipe_3, e.p3);
        chk("coin", coin, e.cn);
        chk("hit", hit, e.ht);
        if (e.evt) begin
          chk("pass_pulse", pass_pulse, e.pp);
          chk("coin_pulse", coin_pulse, e.cp);
          evt_now = 1'b1;
        end
      end
      if (!evt_now) chk("quiet_pulses", {pass_pulse, coin_pulse}, 2'b00);
    end
  end

  // One frame: tick at negedge c0, words due at c0+2, events at c0+3
  task automatic do_frame(input bit extra);
    int          c0, fr, ocx, y;
    logic [15:0] lv, r;
    int          oldx [3];
    bit          pp, cp, col;
    c0 = cyc;
    lv = lfsr_next(m_lfsr);
    f_tick = 1'b1;
    if (frozen) begin
      push(c0 + 2, 1'b0, 1'b0, 1'b0, 1'b1);
      push(c0 + 3, 1'b1, 1'b0, 1'b0, 1'b1);
    end else begin
      fr = -1;
      for (int k = 0; k < 3; k++) begin
        oldx[k] = int'(mx[k]);
        if (mx[k] < 10'd2) begin
          r = rotl(lv, 5 * (k + 1));
          mx[k] = mx[k] - 10'd2 + 10'd660;
          mh[k] = 10'd60 + {2'b00, r[7:0]};
          mg[k] = 8'd100 + {2'b00, r[13:10], 2'b00};
          if (fr < 0) fr = k;
        end else begin
          mx[k] = mx[k] - 10'd2;
        end
      end
      if (mcv) begin
        if (mcx < 10'd2) mcv = 1'b0;
        mcx = mcx - 10'd2;
      end else if (fr >= 0 && lv[15]) begin
        mcx = mx[fr] + 10'd17;
        mcy = mh[fr] + 10'(mg[fr] >> 1) - 10'd8;
        mcv = 1'b1;
      end
      push(c0 + 2, 1'b0, 1'b0, 1'b0, 1'b0);
      y = int'(mario_y);
      pp = 1'b0;
      col = (y + 16 >= 480);
      for (int k = 0; k < 3; k++) begin
        if (oldx[k] >= 22 && int'(mx[k]) < 22) pp = 1'b1;
        if (mx[k] > 20 && mx[k] < 86 &&
            (y < int'(mh[k]) || y + 16 > int'(mh[k]) + int'(mg[k]))) col = 1'b1;
      end
      ocx = int'(mcx) - 70;
      if (ocx < 0) ocx = -ocx;
      cp = mcv && ocx < 16 && ((y > int'(mcy)) ? y - int'(mcy) : int'(mcy) - y) < 16;
      if (cp) mcv = 1'b0;
      frozen = col;
      push(c0 + 3, 1'b1, pp, cp, col);
    end
    @(negedge clk);
    f_tick = extra;
    @(negedge clk);
    f_tick = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  function automatic bit pipe_in_zone();
    bit z = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (mx[k] >= 10'd2 && mx[k] - 10'd2 > 10'd20 && mx[k] - 10'd2 < 10'd86) z = 1'b1;
    end
    return z;
  endfunction

  // Keep the character inside the gap of whichever pipe will be in the danger zone
  task automatic pick_safe();
    int y, ncx;
    y = $urandom_range(0, 400);
    for (int k = 0; k < 3; k++) begin
      if (mx[k] >= 10'd2 && mx[k] - 10'd2 > 10'd20 && mx[k] - 10'd2 < 10'd86)
        y = $urandom_range(int'(mh[k]), int'(mh[k]) + int'(mg[k]) - 16);
    end
    if (mcv && mcx >= 10'd2) begin
      ncx = int'(mcx) - 2 - 70;
      if (ncx < 0) ncx = -ncx;
      if (ncx < 16 && $urandom_range(0, 1) == 1) y = int'(mcy);
    end
    mario_y = 10'(y);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit crashed;
    rst = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    model_reset();
    push(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 480; i++) begin
      pick_safe();
      do_frame($urandom_range(0, 3) == 0);
    end

    crashed = 1'b0;
    for (int i = 0; i < 300 && !crashed; i++) begin
      if (pipe_in_zone()) begin
        mario_y = 10'd10;
        crashed = 1'b1;
      end else begin
        pick_safe();
      end
      do_frame(1'b0);
    end
    chk("crash_reached", frozen, 1'b1);

    for (int i = 0; i < 3; i++) begin
      mario_y = 10'($urandom_range(0, 400));
      do_frame($urandom_range(0, 1) == 1);
    end

    run = 1'b0;
    model_reset();
    push(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      pick_safe();
      do_frame($urandom_range(0, 3) == 0);
    end
    mario_y = 10'd470;
    do_frame(1'b0);
    do_frame(1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
